max_group_arb: RTL and testbench
================================

MAX_GROUP_ARB -- requirements
Module: max_group_arb

Interface
REQ-001 SHALL have parameter DW, default 16: loc-max data width (signed).
REQ-002 SHALL have parameter TIMEOUT_CYC, default 64: stall limit in cycles, used only when MAX_GROUP_ARB_TIMEOUT_EN is defined.
REQ-003 SHALL have port i_clk, input, 1: single clock; all logic on its rising edge.
REQ-004 SHALL have port i_rst, input, 1: reset, synchronous, active-high.
REQ-005 SHALL have port i_en, input, 1: global enable; low freezes all state, forces o_req_ready=0 and o_valid_max=0.
REQ-006 SHALL have ports i_req_valid[1:0], i_req_loc_max[2][DW], i_req_length_mode[2][4], input: per-requester beat stream.
REQ-007 SHALL have port o_req_ready, output, 2: per-requester ready; a beat transfers when valid&ready.
REQ-008 SHALL have ports o_valid_max (1), o_loc_max (DW), o_length_mode (4), o_rst_loc (1), o_src (1), o_grp_end (1), output: drive to shared acc_max/forwarding datapath.
REQ-009 SHALL have ports o_busy (1) and o_abort (1), output: group in progress; group aborted.

Function
REQ-010 SHALL arbitrate one shared max-accumulation datapath between two requesters, group-atomically.
REQ-011 Group length: N = length_mode-1 beats for modes 3..13; N = 1 for modes 0,1,2,14,15.
REQ-012 FSM states: IDLE, RUN, CLOSE.
REQ-013 IDLE: all ready=0; if any i_req_valid, grant the requester other than last_owner if it is valid, else the valid one; go to RUN next cycle.
REQ-014 RUN: o_req_ready[owner]=i_en, other ready=0; beat counter increments per accepted beat.
REQ-015 Length mode SHALL be latched from the first beat of a group; mid-group changes on i_req_length_mode are ignored.
REQ-016 Each accepted beat SHALL appear on o_valid_max/o_loc_max/o_length_mode(latched)/o_src exactly 1 cycle later (registered); o_valid_max=0 otherwise.
REQ-017 o_grp_end SHALL assert coincident with the output of beat N of a group.
REQ-018 On beat N accepted with N>1: go to CLOSE; last_owner<=owner.
REQ-019 CLOSE: one cycle, no ready; o_rst_loc=1 in the cycle after o_grp_end; then IDLE.
REQ-020 On beat N accepted with N=1: skip CLOSE, no o_rst_loc, go to IDLE; last_owner<=owner.
REQ-021 Minimum group-to-group gap: one IDLE cycle (N=1), CLOSE+IDLE (N>1).
REQ-022 Owner valid low mid-group: wait in RUN, counter holds.
REQ-023 o_busy=1 in RUN and CLOSE.

Reset
REQ-024 On i_rst: state=IDLE, counter=0, last_owner=1 (so requester 0 wins first tie), all outputs 0.
REQ-025 Reset mid-group SHALL discard the partial group without asserting o_grp_end or o_rst_loc; i_rst overrides i_en.

Configuration
REQ-026 With MAX_GROUP_ARB_TIMEOUT_EN defined: in RUN, TIMEOUT_CYC consecutive cycles without an accepted beat SHALL pulse o_abort for one cycle, enter CLOSE (o_rst_loc next cycle), set last_owner<=owner.
REQ-027 Without the macro: no stall counter, o_abort tied 0, RUN waits indefinitely.

Structure
REQ-028 Shared package max_pkg SHALL hold the FSM state typedef, the MODE_GRP_MIN=3/MODE_GRP_MAX=13 constants, and the group-length function.
REQ-029 Sub-module rr_arb2 (2-way round-robin pick from valid + last_owner) is natural; everything else stays flat.

Verification
REQ-030 Req0 only, mode 5, 4 beats 0x0010,0x0020,0x0030,0x0040 back-to-back -> o_valid_max 4 cycles, o_grp_end on 4th, o_rst_loc next cycle, o_src=0.
REQ-031 Both valid continuously, mode 4 -> groups alternate 0,1,0,1; no interleaving of beats within a group.
REQ-032 Req1 mode 2 single beats, continuous -> one beat every 2 cycles, o_grp_end each beat, o_rst_loc never.
REQ-033 Mode changed 5->7 after beat 1 of a group -> group still ends after 4 beats, o_length_mode=5 throughout.
REQ-034 i_rst after beat 2 of 4 -> outputs 0 next cycle, no o_grp_end/o_rst_loc, next group restarts count at 0; i_en low 3 cycles mid-group -> ready 0, no beats lost.
REQ-035 With MAX_GROUP_ARB_TIMEOUT_EN, TIMEOUT_CYC=8, owner stalls after beat 1 -> o_abort at the 8th idle cycle, o_rst_loc next cycle, other requester granted next.

Source files
------------

// File: rtl/max_pkg.sv
// max_pkg: shared FSM state, group-mode bounds and group-length rule for max_group_arb.
package max_pkg;
   typedef enum logic [1:0] {IDLE, RUN, CLOSE} state_t;
   localparam logic [3:0] MODE_GRP_MIN = 4'd3;
   localparam logic [3:0] MODE_GRP_MAX = 4'd13;
   function automatic logic [3:0] grp_len(input logic [3:0] mode);
      return (mode >= MODE_GRP_MIN && mode <= MODE_GRP_MAX) ? mode - 4'd1 : 4'd1;
   endfunction
endpackage

// File: rtl/max_group_arb_rr_arb2.sv
// rr_arb2: two-way round-robin pick, favouring the requester that did not own the last group.
module rr_arb2 (
   input  logic [1:0] valid,
   input  logic       last_owner,
   output logic       any,
   output logic       pick
);
   assign any  = |valid;
   assign pick = valid[~last_owner] ? ~last_owner : last_owner;
endmodule

// File: rtl/max_group_arb.sv
// max_group_arb: group-atomic two-requester arbiter feeding a shared max-accumulation datapath.
// Optional stall abort is built when MAX_GROUP_ARB_TIMEOUT_EN is defined.
module max_group_arb
   import max_pkg::*;
#(
   parameter int DW          = 16,
   parameter int TIMEOUT_CYC = 64
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic                 i_en,
   input  logic [1:0]           i_req_valid,
   input  logic signed [DW-1:0] i_req_loc_max [2],
   input  logic [3:0]           i_req_length_mode [2],
   output logic [1:0]           o_req_ready,
   output logic                 o_valid_max,
   output logic signed [DW-1:0] o_loc_max,
   output logic [3:0]           o_length_mode,
   output logic                 o_rst_loc,
   output logic                 o_src,
   output logic                 o_grp_end,
   output logic                 o_busy,
   output logic                 o_abort
);
   state_t     state;
   logic       owner, last_owner, any, pick, beat, last, stall_hit;
   logic [3:0] cnt, mode_q, mode_eff;
   rr_arb2 u_arb (
      .valid      (i_req_valid),
      .last_owner (last_owner),
      .any        (any),
      .pick       (pick)
   );
   assign o_req_ready = (state == RUN && i_en) ? {owner, ~owner} : 2'b00;
   assign beat        = |(o_req_ready & i_req_valid);
   // the first beat of a group supplies the mode; later beats use the latched copy
   assign mode_eff    = (cnt == 4'd0) ? i_req_length_mode[owner] : mode_q;
   assign last        = cnt + 4'd1 == grp_len(mode_eff);
   assign o_busy      = state != IDLE;
`ifdef MAX_GROUP_ARB_TIMEOUT_EN
   localparam int SW = $clog2(TIMEOUT_CYC + 1);
   logic [SW-1:0] stall;
   assign stall_hit = state == RUN && i_en && !beat && stall == SW'(TIMEOUT_CYC - 1);
   always_ff @(posedge i_clk)
      if (i_rst) stall <= '0;
      else if (i_en) stall <= (state == RUN && !beat && !stall_hit) ? stall + 1'b1 : '0;
`else
   assign stall_hit = TIMEOUT_CYC < 0;
`endif
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state         <= IDLE;
         owner         <= 1'b0;
         last_owner    <= 1'b1;
         cnt           <= '0;
         mode_q        <= '0;
         o_valid_max   <= 1'b0;
         o_loc_max     <= '0;
         o_length_mode <= '0;
         o_rst_loc     <= 1'b0;
         o_src         <= 1'b0;
         o_grp_end     <= 1'b0;
         o_abort       <= 1'b0;
      end else if (i_en) begin
         o_valid_max <= beat;
         o_grp_end   <= beat & last;
         o_rst_loc   <= state == CLOSE;
         o_abort     <= stall_hit;
         if (beat) begin
            o_loc_max     <= i_req_loc_max[owner];
            o_length_mode <= mode_eff;
            o_src         <= owner;
         end
         case (state)
            IDLE: if (any) begin
               owner <= pick;
               state <= RUN;
            end
            RUN: if (beat) begin
               mode_q <= mode_eff;
               cnt    <= last ? 4'd0 : cnt + 4'd1;
               if (last) begin
                  last_owner <= owner;
                  state      <= (grp_len(mode_eff) == 4'd1) ? IDLE : CLOSE;
               end
            end else if (stall_hit) begin
               last_owner <= owner;
               cnt        <= '0;
               state      <= CLOSE;
            end
            CLOSE: state <= IDLE;
            default: state <= IDLE;
         endcase
      end else begin
         o_valid_max <= 1'b0;
         o_grp_end   <= 1'b0;
         o_rst_loc   <= 1'b0;
         o_abort     <= 1'b0;
      end
   end
endmodule

// File: tb/tb_max_group_arb.sv
// tb_max_group_arb: randomized scoreboard bench for max_group_arb (default build, no timeout).
module tb_max_group_arb;
   localparam int DW = 16;
   logic                 i_clk = 1'b0, i_rst = 1'b1, i_en = 1'b1;
   logic [1:0]           i_req_valid = 2'b00;
   logic signed [DW-1:0] i_req_loc_max [2];
   logic [3:0]           i_req_length_mode [2];
   logic [1:0]           o_req_ready;
   logic                 o_valid_max, o_rst_loc, o_src, o_grp_end, o_busy, o_abort;
   logic signed [DW-1:0] o_loc_max;
   logic [3:0]           o_length_mode;
   always #5 i_clk = ~i_clk;
   max_group_arb #(.DW(DW), .TIMEOUT_CYC(64)) dut (
      .i_clk (i_clk), .i_rst (i_rst), .i_en (i_en),
      .i_req_valid (i_req_valid), .i_req_loc_max (i_req_loc_max),
      .i_req_length_mode (i_req_length_mode), .o_req_ready (o_req_ready),
      .o_valid_max (o_valid_max), .o_loc_max (o_loc_max), .o_length_mode (o_length_mode),
      .o_rst_loc (o_rst_loc), .o_src (o_src), .o_grp_end (o_grp_end),
      .o_busy (o_busy), .o_abort (o_abort)
   );
   typedef struct packed {
      logic [15:0] loc;
      logic [3:0]  mode;
      logic        src, last, multi, first;
   } exp_t;
   exp_t        exp_q[$];
   logic [19:0] sq [2][$];
   int          vc[$], gsrc[$];
   int          n_cmp = 0, n_bad = 0, mcyc = 0, acc_cnt = 0;
   int          m_cnt = 0, m_n = 1, m_own = 0;
   logic [3:0]  m_mode = 4'd0;
   logic [1:0]  hold = 2'b00;
   logic        en_val = 1'b1, rst_val = 1'b1;
   logic        en_q = 1'b1, rst_q = 1'b0, rst_pend = 1'b0;
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask
   function automatic int glen(input int m);
      return (m >= 3 && m <= 13) ? m - 1 : 1;
   endfunction
   // group model: a group is N beats from one requester, N and mode fixed by its first beat
   task automatic accept(input int r);
      logic [19:0] e;
      exp_t x;
      e = sq[r].pop_front();
      if (m_cnt == 0) begin
         m_own  = r;
         m_mode = e[19:16];
         m_n    = glen(int'(e[19:16]));
      end else chk("owner_held", r, m_own);
      m_cnt++;
      x.loc   = e[15:0];
      x.mode  = m_mode;
      x.src   = r[0];
      x.first = m_cnt == 1;
      x.last  = m_cnt == m_n;
      x.multi = m_n > 1;
      exp_q.push_back(x);
      acc_cnt++;
      if (x.last) m_cnt = 0;
   endtask
   task automatic step();
      logic [1:0]  v;
      logic [19:0] h;
      for (int r = 0; r < 2; r++) begin
         v[r] = !rst_val && !hold[r] && sq[r].size() > 0;
         h = v[r] ? sq[r][0] : 20'($urandom);
         i_req_loc_max[r]     = h[15:0];
         i_req_length_mode[r] = h[19:16];
      end
      i_req_valid = v;
      i_en        = en_val;
      i_rst       = rst_val;
      #1;
      chk("ready_onehot", 32'($countones(o_req_ready) <= 1), 1);
      if (!en_val || !o_busy) chk("ready_idle", o_req_ready, 0);
      if (rst_val) m_cnt = 0;
      else for (int r = 0; r < 2; r++) if (v[r] && o_req_ready[r]) accept(r);
      @(negedge i_clk);
   endtask
   task automatic drain(input int budget);
      int k = 0;
      hold   = 2'b00;
      en_val = 1'b1;
      while ((sq[0].size() > 0 || sq[1].size() > 0 || m_cnt != 0) && k < budget) begin
         if (m_cnt != 0 && sq[m_own].size() == 0) sq[m_own].push_back(20'($urandom));
         step();
         k++;
      end
      if (k == budget) begin
         n_cmp++;
         n_bad++;
         $display("FAIL drain_timeout: still pending after %0d cycles", budget);
      end
      repeat (4) step();
      chk("exp_empty", exp_q.size(), 0);
   endtask
   always @(posedge i_clk) begin
      en_q  <= i_en;
      rst_q <= i_rst;
   end
   always @(negedge i_clk) begin : mon
      exp_t e;
      logic set;
      mcyc++;
      set = 1'b0;
      if (rst_q) begin
         chk("rst_outs", {o_valid_max, o_grp_end, o_rst_loc, o_busy, o_abort, o_src, o_req_ready}, 0);
         chk("rst_data", {o_loc_max, o_length_mode}, 0);
         rst_pend = 1'b0;
      end else begin
         if (o_valid_max) begin
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL unexpected_beat: got loc %0h want no beat", o_loc_max);
            end else begin
               e = exp_q.pop_front();
               chk("loc", $unsigned(o_loc_max), e.loc);
               chk("mode", o_length_mode, e.mode);
               chk("src", o_src, e.src);
               chk("grp_end", o_grp_end, e.last);
               vc.push_back(mcyc);
               if (e.first) gsrc.push_back(int'(o_src));
               set = e.last && e.multi;
            end
         end else chk("grp_end_idle", o_grp_end, 0);
         chk("rst_loc", o_rst_loc, en_q ? rst_pend : 1'b0);
         if (en_q) rst_pend = 1'b0;
         rst_pend |= set;
         chk("abort", o_abort, 0);
      end
   end
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end
   initial begin
      @(negedge i_clk);
      step();
      step();
      rst_val = 1'b0;
      // single requester, four back-to-back beats
      for (int i = 0; i < 4; i++) sq[0].push_back({4'd5, 16'(16 * (i + 1))});
      drain(100);
      chk("p1_beats", vc.size(), 4);
      for (int i = 1; i < vc.size(); i++) chk("p1_b2b", vc[i] - vc[i-1], 1);
      vc.delete();
      gsrc.delete();
      // single-beat groups: one beat every two cycles
      repeat (6) sq[1].push_back({4'd2, 16'($urandom)});
      drain(100);
      chk("p2_beats", vc.size(), 6);
      for (int i = 1; i < vc.size(); i++) chk("p2_gap", vc[i] - vc[i-1], 2);
      vc.delete();
      gsrc.delete();
      // both requesters contend: groups must alternate starting with 0
      for (int i = 0; i < 6; i++) begin
         sq[0].push_back({4'd4, 16'($urandom)});
         sq[1].push_back({4'd4, 16'($urandom)});
      end
      drain(200);
      chk("p3_groups", gsrc.size(), 4);
      for (int i = 0; i < gsrc.size(); i++) chk("p3_alt", gsrc[i], i % 2);
      // mode changes after first beat are ignored
      sq[0].push_back({4'd5, 16'h1111});
      for (int i = 0; i < 3; i++) sq[0].push_back({4'd7, 16'(16'h2222 + i)});
      drain(100);
      // reset after beat 2 of 4 discards the partial group
      for (int i = 0; i < 4; i++) sq[0].push_back({4'd5, 16'hA000 + 16'(i)});
      acc_cnt = 0;
      for (int k = 0; k < 50 && acc_cnt < 2; k++) step();
      rst_val = 1'b1;
      step();
      rst_val = 1'b0;
      drain(100);
      // enable low for three cycles mid-group
      for (int i = 0; i < 4; i++) sq[1].push_back({4'd5, 16'hB000 + 16'(i)});
      acc_cnt = 0;
      for (int k = 0; k < 50 && acc_cnt < 1; k++) step();
      en_val = 1'b0;
      repeat (3) step();
      en_val = 1'b1;
      drain(100);
      // randomized traffic with stalls and enable drops
      repeat (800) begin
         if ($urandom_range(0, 2) == 0) begin
            int r;
            r = int'($urandom_range(0, 1));
            if (sq[r].size() < 8) sq[r].push_back(20'($urandom));
         end
         hold[0] = $urandom_range(0, 4) == 0;
         hold[1] = $urandom_range(0, 4) == 0;
         en_val  = $urandom_range(0, 15) != 0;
         step();
      end
      drain(500);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
